keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad, clocked at 100 Hz. It drives the active-low row lines and samples the active-low column lines. When a press is debounced it stops on the active row, encodes the key and presents it to the downstream consumer through a valid/ack handshake. It then waits for a debounced release before scanning resumes.

---
 rtl/keypad_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce,
// key encode and valid/ack handoff. Optional macro: KEYPAD_REPEAT_EN.
//
// Ports:
//   CLK_100HZ  in   100 Hz scan clock
//   RESET      in   asynchronous, active-high
//   COL_IN     in   [3:0] columns, active low, pre-synchronised
//   ROW_OUT    out  [3:0] rows, active low, one row driven at a time
//   ROW_IDX    out  [1:0] index of the driven row
//   KEY_CODE   out  [3:0] {row_idx, col_idx} of the reported key
//   KEY_VALID  out  key pending, held until acknowledged
//   KEY_ACK    in   consumer accepts the pending key
//   OVERRUN    out  sticky: a key was dropped while one was pending
//   KEY_HELD   out  high while a debounced key is down (or releasing)
//
// KEYPAD_REPEAT_EN: when defined, a held key is re-emitted after
// REPEAT_DLY cycles and then every REPEAT_RATE cycles.
module keypad_scan_ctrl #(
   parameter int DEBOUNCE_CNT = 3,
   parameter int REPEAT_DLY   = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic       CLK_100HZ,
   input  logic       RESET,
   input  logic [3:0] COL_IN,
   output logic [3:0] ROW_OUT,
   output logic [1:0] ROW_IDX,
   output logic [3:0] KEY_CODE,
   output logic       KEY_VALID,
   input  logic       KEY_ACK,
   output logic       OVERRUN,
   output logic       KEY_HELD
);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

   // Elaboration-time sanity checks on the configuration.
   if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 15) begin : g_bad_db
      $error("DEBOUNCE_CNT out of range 2..15");
   end
   if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_bad_rep
      $error("REPEAT_RATE must be 1..REPEAT_DLY");
   end

   logic [1:0] state;
   logic [3:0] col_lat;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic [1:0] col_idx;
   logic       idle;
   logic       emit;
   logic       emit_press;
   logic       emit_rep;
   logic       blocked;

   assign idle    = (COL_IN == 4'b1111);
   assign cnt_nxt = cnt + 4'd1;

   assign emit_press = (state == DEBOUNCE)
                    && (COL_IN == col_lat)
                    && (cnt_nxt == DB_LAST);

   assign emit     = emit_press | emit_rep;
   assign KEY_HELD = (state == PRESSED) || (state == RELEASE);

   // Pending key not being taken this edge: a new one is dropped.
   assign blocked = KEY_VALID & ~KEY_ACK;

   always_comb begin
      ROW_OUT = 4'b1110;
      unique case (ROW_IDX)
         2'd0: ROW_OUT = 4'b1110;
         2'd1: ROW_OUT = 4'b1101;
         2'd2: ROW_OUT = 4'b1011;
         2'd3: ROW_OUT = 4'b0111;
         default: ROW_OUT = 4'b1110;
      endcase
   end

   // Lowest-numbered low column wins on multi-key chords.
   always_comb begin
      col_idx = 2'd0;
      if (!col_lat[0])      col_idx = 2'd0;
      else if (!col_lat[1]) col_idx = 2'd1;
      else if (!col_lat[2]) col_idx = 2'd2;
      else if (!col_lat[3]) col_idx = 2'd3;
   end

   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         state   <= SCAN;
         ROW_IDX <= 2'd0;
         col_lat <= 4'b1111;
         cnt     <= 4'd0;
      end else begin
         unique case (state)
            SCAN: begin
               if (idle) begin
                  ROW_IDX <= ROW_IDX + 2'd1;
               end else begin
                  col_lat <= COL_IN;
                  cnt     <= 4'd1;
                  state   <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (COL_IN == col_lat) begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == DB_LAST) state <= PRESSED;
               end else begin
                  state   <= SCAN;
                  ROW_IDX <= ROW_IDX + 2'd1;
               end
            end
            PRESSED: begin
               if (idle) begin
                  state <= RELEASE;
                  cnt   <= 4'd1;
               end
            end
            RELEASE: begin
               if (idle) begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == DB_LAST) begin
                     state   <= SCAN;
                     ROW_IDX <= ROW_IDX + 2'd1;
                  end
               end else begin
                  state <= PRESSED;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

`ifdef KEYPAD_REPEAT_EN
   logic [15:0] hold_cnt;
   logic [15:0] hold_nxt;

   assign hold_nxt = hold_cnt + 16'd1;
   assign emit_rep = (state == PRESSED) && !idle
                  && (hold_nxt == 16'(REPEAT_DLY));

   // After each repeat the counter is pulled back so the next
   // match lands REPEAT_RATE cycles later.
   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         hold_cnt <= 16'd0;
      end else if (emit_press) begin
         hold_cnt <= 16'd0;
      end else if (state == PRESSED) begin
         if (idle)
            hold_cnt <= 16'd0;
         else if (emit_rep)
            hold_cnt <= 16'(REPEAT_DLY - REPEAT_RATE);
         else
            hold_cnt <= hold_nxt;
      end
   end
`else
   assign emit_rep = 1'b0;
`endif

   always_ff @(posedge CLK_100HZ or posedge RESET) begin
      if (RESET) begin
         KEY_CODE  <= 4'd0;
         KEY_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else if (emit && !blocked) begin
         KEY_CODE  <= {ROW_IDX, col_idx};
         KEY_VALID <= 1'b1;
         OVERRUN   <= 1'b0;
      end else if (emit) begin
         OVERRUN   <= 1'b1;
      end else if (KEY_ACK && KEY_VALID) begin
         KEY_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl.
// Expected key codes and emission cycles are queued, then popped.
module tb_keypad_scan_ctrl;

   logic       CLK_100HZ;
   logic       RESET;
   logic [3:0] COL_IN;
   logic [3:0] ROW_OUT;
   logic [1:0] ROW_IDX;
   logic [3:0] KEY_CODE;
   logic       KEY_VALID;
   logic       KEY_ACK;
   logic       OVERRUN;
   logic       KEY_HELD;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [3:0] exp_q [$];
   int         cyc_q [$];

   keypad_scan_ctrl dut (
      .CLK_100HZ (CLK_100HZ),
      .RESET     (RESET),
      .COL_IN    (COL_IN),
      .ROW_OUT   (ROW_OUT),
      .ROW_IDX   (ROW_IDX),
      .KEY_CODE  (KEY_CODE),
      .KEY_VALID (KEY_VALID),
      .KEY_ACK   (KEY_ACK),
      .OVERRUN   (OVERRUN),
      .KEY_HELD  (KEY_HELD)
   );

   initial CLK_100HZ = 1'b0;
   always #5 CLK_100HZ = ~CLK_100HZ;

   task automatic step();
      @(negedge CLK_100HZ);
   endtask

   task automatic wait_row(input logic [1:0] r);
      int n;
      n = 0;
      while (ROW_IDX !== r && n < 8) begin
         step();
         n++;
      end
      chk_cnt++;
      if (ROW_IDX !== r)
         $display("FAIL wait_row: got %0d want %0d", ROW_IDX, r);
      else pass_cnt++;
   endtask

   task automatic pop_key(input string nm);
      logic [3:0] e;
      chk_cnt++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: key %h with empty queue", nm, KEY_CODE);
      end else begin
         e = exp_q.pop_front();
         if (KEY_CODE !== e)
            $display("FAIL %s: code %h want %h", nm, KEY_CODE, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      RESET   = 1'b1;
      COL_IN  = 4'b1111;
      KEY_ACK = 1'b0;
      step();
      step();
      RESET = 1'b0;
      chk_cnt++;
      if (ROW_OUT !== 4'b1110 || ROW_IDX !== 2'd0)
         $display("FAIL rst_row: %b/%0d want 1110/0", ROW_OUT, ROW_IDX);
      else pass_cnt++;
      chk_cnt++;
      if ({KEY_CODE, KEY_VALID, OVERRUN, KEY_HELD} !== 7'd0)
         $display("FAIL rst_key: code %h v%b o%b h%b want 0",
                  KEY_CODE, KEY_VALID, OVERRUN, KEY_HELD);
      else pass_cnt++;
   endtask

   task automatic test_scan();
      logic [3:0] rows [4];
      rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      for (int i = 0; i < 4; i++) begin
         step();
         chk_cnt++;
         if (ROW_OUT !== rows[i] || KEY_VALID !== 1'b0)
            $display("FAIL scan%0d: row %b v%b want %b v0",
                     i, ROW_OUT, KEY_VALID, rows[i]);
         else pass_cnt++;
      end
   endtask

   task automatic release_key();
      COL_IN = 4'b1111;
      repeat (3) step();
   endtask

   task automatic test_press();
      wait_row(2'd2);
      COL_IN = 4'b1011;
      exp_q.push_back(4'hA);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_cnt++;
         if (KEY_VALID !== 1'b0 || ROW_IDX !== 2'd2)
            $display("FAIL press_early%0d: v%b row %0d want v0 row 2",
                     i, KEY_VALID, ROW_IDX);
         else pass_cnt++;
      end
      step();
      chk_cnt++;
      if (KEY_VALID !== 1'b1 || KEY_HELD !== 1'b1)
         $display("FAIL press_valid: v%b h%b want 1 1",
                  KEY_VALID, KEY_HELD);
      else pass_cnt++;
      pop_key("press_code");
      KEY_ACK = 1'b1;
      step();
      KEY_ACK = 1'b0;
      chk_cnt++;
      if (KEY_VALID !== 1'b0)
         $display("FAIL ack_clear: v%b want 0", KEY_VALID);
      else pass_cnt++;
      COL_IN = 4'b1111;
      step();
      step();
      chk_cnt++;
      if (ROW_IDX !== 2'd2 || KEY_HELD !== 1'b1)
         $display("FAIL rel_hold: row %0d h%b want 2 1",
                  ROW_IDX, KEY_HELD);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (ROW_IDX !== 2'd3 || KEY_HELD !== 1'b0)
         $display("FAIL rel_resume: row %0d h%b want 3 0",
                  ROW_IDX, KEY_HELD);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      wait_row(2'd1);
      COL_IN = 4'b1110;
      step();
      chk_cnt++;
      if (ROW_IDX !== 2'd1)
         $display("FAIL glitch_hold: row %0d want 1", ROW_IDX);
      else pass_cnt++;
      COL_IN = 4'b1111;
      step();
      chk_cnt++;
      if (ROW_IDX !== 2'd2 || KEY_VALID !== 1'b0 || KEY_HELD !== 1'b0)
         $display("FAIL glitch_drop: row %0d v%b h%b want 2 0 0",
                  ROW_IDX, KEY_VALID, KEY_HELD);
      else pass_cnt++;
   endtask

   task automatic test_overrun();
      wait_row(2'd0);
      COL_IN = 4'b1001;
      exp_q.push_back(4'h1);
      repeat (3) step();
      chk_cnt++;
      if (KEY_VALID !== 1'b1)
         $display("FAIL ovr_first: v%b want 1", KEY_VALID);
      else pass_cnt++;
      pop_key("ovr_chord");
      release_key();
      wait_row(2'd3);
      COL_IN = 4'b1110;
      repeat (3) step();
      chk_cnt++;
      if (KEY_CODE !== 4'h1 || KEY_VALID !== 1'b1 || OVERRUN !== 1'b1)
         $display("FAIL ovr_drop: code %h v%b o%b want 1 1 1",
                  KEY_CODE, KEY_VALID, OVERRUN);
      else pass_cnt++;
      KEY_ACK = 1'b1;
      step();
      KEY_ACK = 1'b0;
      chk_cnt++;
      if (KEY_VALID !== 1'b0 || OVERRUN !== 1'b0)
         $display("FAIL ovr_ack: v%b o%b want 0 0", KEY_VALID, OVERRUN);
      else pass_cnt++;
      release_key();
   endtask

   task automatic test_back_to_back();
      wait_row(2'd1);
      COL_IN = 4'b0111;
      exp_q.push_back(4'h7);
      repeat (3) step();
      chk_cnt++;
      if (KEY_VALID !== 1'b1)
         $display("FAIL b2b_first: v%b want 1", KEY_VALID);
      else pass_cnt++;
      pop_key("b2b_code1");
      release_key();
      wait_row(2'd2);
      COL_IN = 4'b1110;
      exp_q.push_back(4'h8);
      step();
      step();
      KEY_ACK = 1'b1;
      step();
      chk_cnt++;
      if (KEY_VALID !== 1'b1 || OVERRUN !== 1'b0)
         $display("FAIL b2b_keep: v%b o%b want 1 0", KEY_VALID, OVERRUN);
      else pass_cnt++;
      pop_key("b2b_code2");
      step();
      KEY_ACK = 1'b0;
      chk_cnt++;
      if (KEY_VALID !== 1'b0)
         $display("FAIL b2b_ack: v%b want 0", KEY_VALID);
      else pass_cnt++;
      release_key();
   endtask

   task automatic test_repeat();
      int e;
      int seen;
      int want;
`ifdef KEYPAD_REPEAT_EN
      cyc_q = '{3, 53, 63, 73};
`else
      cyc_q = '{3};
`endif
      want = cyc_q.size();
      seen = 0;
      wait_row(2'd1);
      COL_IN  = 4'b1011;
      KEY_ACK = 1'b1;
      for (int n = 1; n <= 82; n++) begin
         step();
         if (KEY_VALID === 1'b1) begin
            seen++;
            chk_cnt++;
            if (cyc_q.size() == 0) begin
               $display("FAIL rep_extra: emission at %0d", n);
            end else begin
               e = cyc_q.pop_front();
               if (n !== e || KEY_CODE !== 4'h6)
                  $display("FAIL rep_emit: cyc %0d code %h want %0d 6",
                           n, KEY_CODE, e);
               else pass_cnt++;
            end
         end
      end
      chk_cnt++;
      if (seen !== want)
         $display("FAIL rep_count: got %0d want %0d", seen, want);
      else pass_cnt++;
      release_key();
      KEY_ACK = 1'b0;
   endtask

   task automatic test_async_reset();
      wait_row(2'd3);
      COL_IN = 4'b1101;
      exp_q.push_back(4'hD);
      repeat (3) step();
      chk_cnt++;
      if (KEY_VALID !== 1'b1 || KEY_HELD !== 1'b1)
         $display("FAIL ar_pre: v%b h%b want 1 1", KEY_VALID, KEY_HELD);
      else pass_cnt++;
      pop_key("ar_code");
      #2 RESET = 1'b1;
      #1;
      chk_cnt++;
      if ({KEY_CODE, KEY_VALID, OVERRUN, KEY_HELD} !== 7'd0)
         $display("FAIL ar_key: code %h v%b o%b h%b want 0",
                  KEY_CODE, KEY_VALID, OVERRUN, KEY_HELD);
      else pass_cnt++;
      chk_cnt++;
      if (ROW_OUT !== 4'b1110 || ROW_IDX !== 2'd0)
         $display("FAIL ar_row: %b/%0d want 1110/0", ROW_OUT, ROW_IDX);
      else pass_cnt++;
      COL_IN = 4'b1111;
      step();
      RESET = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_scan();
      test_press();
      test_glitch();
      test_overrun();
      test_back_to_back();
      test_repeat();
      test_async_reset();
      chk_cnt++;
      if (exp_q.size() != 0)
         $display("FAIL sb_left: %0d keys unseen", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
